// File: rtl/digit_scan_pkg.sv
// Shared constants, state encoding and digit extraction for the four-digit scan controller.
package digit_scan_pkg;

    localparam int unsigned DIGITS           = 4;
    localparam int unsigned NIBBLE_W         = 4;
    localparam int unsigned IDX_W            = 2;
    localparam int unsigned WORD_W           = DIGITS * NIBBLE_W;
    localparam int unsigned PRESCALE_DEFAULT = 50000;
    localparam int unsigned BLANK_DEFAULT    = 1000;

    typedef enum logic [1:0] {
        StStop,
        StBlank,
        StShow
    } scan_state_t;

    function automatic logic [NIBBLE_W-1:0] digit_of(input logic [WORD_W-1:0] word,
                                                     input logic [IDX_W-1:0]  idx);
        logic [WORD_W-1:0] shifted;
        shifted = word >> (idx * NIBBLE_W);
        return shifted[NIBBLE_W-1:0];
    endfunction

endpackage

// File: rtl/slot_timer.sv
// Per-digit slot prescaler: counts 0..PRESCALE-1, flags the last cycle and the blanking window.
module slot_timer
    import digit_scan_pkg::*;
#(
    parameter int unsigned PRESCALE = PRESCALE_DEFAULT,
    parameter int unsigned BLANK    = BLANK_DEFAULT,
    localparam int unsigned CNT_W   = $clog2(PRESCALE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             in_blank_o,
    output logic             slot_end_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        slot_end_o = (cnt_q == CNT_W'(PRESCALE - 1));
        cnt_d      = cnt_q + CNT_W'(1);
        if (clr_i || slot_end_o) begin
            cnt_d = '0;
        end
        // Blanking is judged on the count being loaded, so callers can register
        // their enable alongside the counter and keep it aligned.
        in_blank_o = int'(cnt_d) < int'(BLANK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/digit_scan_ctrl.sv
// Four-digit display scan controller: slot sequencing, frame-aligned word commit and load handshake.
module digit_scan_ctrl
    import digit_scan_pkg::*;
#(
    parameter int unsigned PRESCALE = PRESCALE_DEFAULT,
    parameter int unsigned BLANK    = BLANK_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                load,
    input  logic [WORD_W-1:0]   data_in,
    output logic                ready,
    output logic                overrun,
    output logic                en_n,
    output logic                sel_a,
    output logic                sel_b,
    output logic [NIBBLE_W-1:0] nibble,
    output logic                frame_done
);

    localparam int unsigned CNT_W = $clog2(PRESCALE);

    scan_state_t          state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [WORD_W-1:0]    shadow_q, shadow_d;
    logic [WORD_W-1:0]    pending_q, pending_d;
    logic                 pend_valid_q, pend_valid_d;
    logic                 en_n_q, en_n_d;
    logic [NIBBLE_W-1:0]  nibble_q, nibble_d;
    logic                 frame_done_q, frame_done_d;
    logic                 overrun_q, overrun_d;

    logic                 running;
    logic                 advance;
    logic                 wrap;
    logic                 commit;
    logic [CNT_W-1:0]     slot_cnt;
    logic                 in_blank;
    logic                 slot_end;
    logic                 unused_slot_cnt;

    // A stopped controller restarts slot 0 from cnt=0, so the timer is held clear
    // for the cycle in which run is first seen high.
    assign running = run && (state_q != StStop);

    slot_timer #(
        .PRESCALE (PRESCALE),
        .BLANK    (BLANK)
    ) u_slot_timer (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (!running),
        .cnt_o      (slot_cnt),
        .in_blank_o (in_blank),
        .slot_end_o (slot_end)
    );

    assign unused_slot_cnt = ^slot_cnt;

    always_comb begin
        state_d      = StStop;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        pend_valid_d = pend_valid_q;

        advance = running && slot_end;
        wrap    = advance && (idx_q == IDX_W'(DIGITS - 1));
        commit  = pend_valid_q && (wrap || (state_q == StStop));

        if (!run) begin
            state_d = StStop;
            idx_d   = '0;
        end else begin
            state_d = in_blank ? StBlank : StShow;
            if (advance) begin
                idx_d = idx_q + IDX_W'(1);
            end
        end

        if (commit) begin
            shadow_d     = pending_q;
            pend_valid_d = 1'b0;
        end

        // ready is still low during a commit cycle, so a load there is an overrun.
        if (load && !pend_valid_q) begin
            pending_d    = data_in;
            pend_valid_d = 1'b1;
        end

        overrun_d    = load && pend_valid_q;
        frame_done_d = wrap;
        en_n_d       = (state_d != StShow);
        nibble_d     = digit_of(shadow_d, idx_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StStop;
            idx_q        <= '0;
            shadow_q     <= '0;
            pending_q    <= '0;
            pend_valid_q <= 1'b0;
            en_n_q       <= 1'b1;
            nibble_q     <= '0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            pend_valid_q <= pend_valid_d;
            en_n_q       <= en_n_d;
            nibble_q     <= nibble_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign ready      = !pend_valid_q;
    assign overrun    = overrun_q;
    assign en_n       = en_n_q;
    assign sel_a      = idx_q[1];
    assign sel_b      = idx_q[0];
    assign nibble     = nibble_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench for digit_scan_ctrl with PRESCALE=8, BLANK=2 (slot = 8 cycles, frame = 32).
module tb_digit_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        run;
    logic        load;
    logic [15:0] data_in;
    logic        ready;
    logic        overrun;
    logic        en_n;
    logic        sel_a;
    logic        sel_b;
    logic [3:0]  nibble;
    logic        frame_done;

    int errors;
    int checks;

    digit_scan_ctrl #(
        .PRESCALE (8),
        .BLANK    (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .load       (load),
        .data_in    (data_in),
        .ready      (ready),
        .overrun    (overrun),
        .en_n       (en_n),
        .sel_a      (sel_a),
        .sel_b      (sel_b),
        .nibble     (nibble),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 1 time unit after each rising edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        logic [9:0] obs;
        logic [9:0] exp;
        rst     = 1'b1;
        run     = 1'b1;
        load    = 1'b0;
        data_in = 16'h0000;
        exp     = {1'b1, 2'b00, 4'h0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            step(1);
            obs = {en_n, sel_a, sel_b, nibble, ready, frame_done, overrun};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_cycle%0d outputs got=%b want=%b", i, obs, exp);
            end
        end
        rst = 1'b0;
        run = 1'b0;
    endtask

    task automatic test_first_load_and_scan();
        logic [15:0] w;
        int          slot;
        int          c;
        logic [3:0]  exp_nib;
        int          fd_count;
        w       = 16'h4321;
        load    = 1'b1;
        data_in = w;
        step(1);
        load = 1'b0;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL stop_load_ready_low got=%b want=0", ready);
        end
        step(1);
        checks++;
        if ({ready, en_n, nibble} !== {1'b1, 1'b1, 4'h1}) begin
            errors++;
            $display("FAIL stop_commit ready/en_n/nibble got=%b/%b/%h want=1/1/1",
                     ready, en_n, nibble);
        end
        run = 1'b1;
        step(1);
        fd_count = 0;
        for (int i = 0; i < 32; i++) begin
            slot    = i / 8;
            c       = i % 8;
            exp_nib = w[4*slot +: 4];
            checks++;
            if ({en_n, sel_a, sel_b, nibble} !== {(c < 2), 2'(slot), exp_nib}) begin
                errors++;
                $display("FAIL scan_pos%0d en_n/sel/nibble got=%b/%b%b/%h want=%b/%0d/%h",
                         i, en_n, sel_a, sel_b, nibble, (c < 2), slot, exp_nib);
            end
            if (frame_done === 1'b1) fd_count++;
            step(1);
        end
        checks++;
        if (fd_count !== 0) begin
            errors++;
            $display("FAIL frame_done_early got=%0d pulses want=0", fd_count);
        end
        checks++;
        if ({frame_done, en_n, sel_a, sel_b, nibble} !== {1'b1, 1'b1, 2'b00, 4'h1}) begin
            errors++;
            $display("FAIL wrap_cycle32 fd/en_n/sel/nibble got=%b/%b/%b%b/%h want=1/1/00/1",
                     frame_done, en_n, sel_a, sel_b, nibble);
        end
    endtask

    // Enters at frame position 0; leaves at position 9 with 0xABCD pending.
    task automatic test_mid_frame_load();
        step(8);
        load    = 1'b1;
        data_in = 16'hABCD;
        step(1);
        load = 1'b0;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL midframe_ready_low got=%b want=0", ready);
        end
    endtask

    // Enters at position 9; finishes one full frame after the commit (position 0).
    task automatic test_overrun();
        logic [15:0] w_old;
        logic [15:0] w_new;
        logic [3:0]  exp_nib;
        int          slot;
        w_old   = 16'h4321;
        w_new   = 16'hABCD;
        load    = 1'b1;
        data_in = 16'h5555;
        step(1);
        load = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_pulse got=%b want=1", overrun);
        end
        step(1);
        checks++;
        if ({overrun, ready} !== 2'b00) begin
            errors++;
            $display("FAIL overrun_width overrun/ready got=%b/%b want=0/0", overrun, ready);
        end
        for (int i = 11; i < 32; i++) begin
            slot    = i / 8;
            exp_nib = w_old[4*slot +: 4];
            checks++;
            if ({nibble, ready} !== {exp_nib, 1'b0}) begin
                errors++;
                $display("FAIL old_word_pos%0d nibble/ready got=%h/%b want=%h/0",
                         i, nibble, ready, exp_nib);
            end
            step(1);
        end
        checks++;
        if ({frame_done, ready, nibble} !== {1'b1, 1'b1, 4'hD}) begin
            errors++;
            $display("FAIL commit_wrap fd/ready/nibble got=%b/%b/%h want=1/1/d",
                     frame_done, ready, nibble);
        end
        for (int i = 0; i < 32; i++) begin
            slot    = i / 8;
            exp_nib = w_new[4*slot +: 4];
            checks++;
            if ({en_n, sel_a, sel_b, nibble} !== {((i % 8) < 2), 2'(slot), exp_nib}) begin
                errors++;
                $display("FAIL new_word_pos%0d en_n/sel/nibble got=%b/%b%b/%h want=%b/%0d/%h",
                         i, en_n, sel_a, sel_b, nibble, ((i % 8) < 2), slot, exp_nib);
            end
            step(1);
        end
    endtask

    // Enters at position 0; a load presented on the commit edge must be dropped.
    task automatic test_load_at_commit();
        load    = 1'b1;
        data_in = 16'h1357;
        step(1);
        load = 1'b0;
        step(30);
        load    = 1'b1;
        data_in = 16'h2468;
        step(1);
        load = 1'b0;
        checks++;
        if ({overrun, ready, frame_done, nibble} !== {1'b1, 1'b1, 1'b1, 4'h7}) begin
            errors++;
            $display("FAIL load_at_commit ovr/ready/fd/nibble got=%b/%b/%b/%h want=1/1/1/7",
                     overrun, ready, frame_done, nibble);
        end
        step(1);
        checks++;
        if ({overrun, ready} !== 2'b01) begin
            errors++;
            $display("FAIL after_commit ovr/ready got=%b/%b want=0/1", overrun, ready);
        end
    endtask

    // Enters at position 1 with shadow 0x1357.
    task automatic test_reset_mid();
        logic [9:0] obs;
        logic [9:0] exp;
        load    = 1'b1;
        data_in = 16'h9999;
        step(1);
        load = 1'b0;
        step(16);
        checks++;
        if ({en_n, sel_a, sel_b, nibble, ready} !== {1'b0, 2'b10, 4'h3, 1'b0}) begin
            errors++;
            $display("FAIL pre_reset_show en_n/sel/nibble/ready got=%b/%b%b/%h/%b want=0/10/3/0",
                     en_n, sel_a, sel_b, nibble, ready);
        end
        rst     = 1'b1;
        load    = 1'b1;
        data_in = 16'h7777;
        step(1);
        obs = {en_n, sel_a, sel_b, nibble, ready, frame_done, overrun};
        exp = {1'b1, 2'b00, 4'h0, 1'b1, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_mid outputs got=%b want=%b", obs, exp);
        end
        rst  = 1'b0;
        load = 1'b0;
        run  = 1'b0;
        step(2);
        checks++;
        if ({nibble, ready, en_n} !== {4'h0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL reset_discard nibble/ready/en_n got=%h/%b/%b want=0/1/1",
                     nibble, ready, en_n);
        end
    endtask

    task automatic test_stop_resume();
        load    = 1'b1;
        data_in = 16'h4321;
        step(1);
        load = 1'b0;
        step(1);
        run = 1'b1;
        step(1);
        step(10);
        checks++;
        if ({en_n, sel_a, sel_b, nibble} !== {1'b0, 2'b01, 4'h2}) begin
            errors++;
            $display("FAIL pre_stop en_n/sel/nibble got=%b/%b%b/%h want=0/01/2",
                     en_n, sel_a, sel_b, nibble);
        end
        run     = 1'b0;
        load    = 1'b1;
        data_in = 16'h8765;
        step(1);
        load = 1'b0;
        checks++;
        if ({en_n, sel_a, sel_b, frame_done, ready, nibble} !==
            {1'b1, 2'b00, 1'b0, 1'b0, 4'h1}) begin
            errors++;
            $display("FAIL stop_entry en_n/sel/fd/ready/nibble got=%b/%b%b/%b/%b/%h want=1/00/0/0/1",
                     en_n, sel_a, sel_b, frame_done, ready, nibble);
        end
        step(1);
        checks++;
        if ({ready, nibble, en_n, frame_done} !== {1'b1, 4'h5, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL stop_commit2 ready/nibble/en_n/fd got=%b/%h/%b/%b want=1/5/1/0",
                     ready, nibble, en_n, frame_done);
        end
        run = 1'b1;
        step(1);
        checks++;
        if ({en_n, sel_a, sel_b, nibble} !== {1'b1, 2'b00, 4'h5}) begin
            errors++;
            $display("FAIL resume_c0 en_n/sel/nibble got=%b/%b%b/%h want=1/00/5",
                     en_n, sel_a, sel_b, nibble);
        end
        step(1);
        checks++;
        if (en_n !== 1'b1) begin
            errors++;
            $display("FAIL resume_c1 en_n got=%b want=1", en_n);
        end
        step(1);
        checks++;
        if ({en_n, nibble} !== {1'b0, 4'h5}) begin
            errors++;
            $display("FAIL resume_c2 en_n/nibble got=%b/%h want=0/5", en_n, nibble);
        end
        step(6);
        checks++;
        if ({en_n, sel_a, sel_b, nibble} !== {1'b1, 2'b01, 4'h6}) begin
            errors++;
            $display("FAIL resume_slot1 en_n/sel/nibble got=%b/%b%b/%h want=1/01/6",
                     en_n, sel_a, sel_b, nibble);
        end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        rst     = 1'b1;
        run     = 1'b0;
        load    = 1'b0;
        data_in = 16'h0000;
        test_reset();
        test_first_load_and_scan();
        test_mid_frame_load();
        test_overrun();
        test_load_at_commit();
        test_reset_mid();
        test_stop_resume();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
